lsu_mem_port: RTL and testbench
===============================

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 SHALL have parameter: ADR_W, 16, memory address width.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: lsu_adr  in  ADR_W  access address from the LSU address buffer.
REQ-005 SHALL have port: sched_valid  in  1  scheduler request strobe.
REQ-006 SHALL have port: sched_op  in  2  00 none, 01 load byte, 10 load word (little-endian), 11 store byte.
REQ-007 SHALL have port: sched_wdata  in  8  store data.
REQ-008 SHALL have port: lsu_busy  out  1  transaction in progress.
REQ-009 SHALL have port: lsu_done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port: lsu_rdata  out  16  load result to ALU.
REQ-011 SHALL have ports: mem_req out 1, mem_we out 1, mem_adr out ADR_W, mem_wdata out 8, mem_rdata in 8, mem_ack in 1 (memory bus).

Function
REQ-012 SHALL accept a request at an edge where sched_valid=1, sched_op!=00 and lsu_busy=0, capturing lsu_adr, sched_op and sched_wdata at that edge.
REQ-013 SHALL ignore requests while busy (no queuing) and requests with op 00.
REQ-014 SHALL implement states IDLE, LO, HI; accept: IDLE->LO; ack in LO: load word ->HI, else ->IDLE; ack in HI ->IDLE.
REQ-015 SHALL drive lsu_busy=1 and mem_req=1 exactly in LO and HI, all bus outputs registered.
REQ-016 SHALL hold mem_adr, mem_we, mem_wdata stable while mem_req=1 until mem_ack is sampled high.
REQ-017 SHALL drive mem_adr=captured address in LO and captured address+1 (mod 2^ADR_W) in HI.
REQ-018 SHALL assert mem_we=1 only in LO of a store byte; mem_wdata=captured data.
REQ-019 SHALL ignore mem_ack when mem_req=0.
REQ-020 SHALL, on final ack, pulse lsu_done for the following cycle; load byte: lsu_rdata={8'h00,mem_rdata}; load word: low byte from LO, high byte from HI; store: lsu_rdata unchanged.
REQ-021 SHALL hold lsu_rdata until the next load completion.
REQ-022 SHALL accept a new request in the cycle lsu_done is high (back-to-back).
REQ-023 SHALL give minimum latency accept edge -> lsu_done high of 2 cycles (byte) and 3 cycles (word) with zero-wait ack.

Reset
REQ-024 SHALL, on rst_n=0 at an edge, enter IDLE and clear lsu_busy, lsu_done, mem_req, mem_we, mem_adr, mem_wdata, lsu_rdata to 0.
REQ-025 SHALL abort any in-flight transaction on reset without lsu_done; mem_req low the cycle after the reset edge.

Configuration
REQ-026 SHALL honour macro LSU_PAGE_WRAP_EN: defined -> HI address = {adr[ADR_W-1:8], adr[7:0]+1} (page wrap); undefined -> full ADR_W increment.

Structure
REQ-027 SHALL place op encodings and the state enum in shared package lsu_pkg.
REQ-028 SHALL be a single module; no sub-module.

Verification
REQ-029 SHALL verify: load byte 0x1234, mem_rdata 0xA5, zero-wait ack -> one bus cycle, lsu_done 2 cycles after accept, lsu_rdata=0x00A5.
REQ-030 SHALL verify: load word 0x2000, data 0x34 then 0x12, 2 wait cycles each -> addresses 0x2000,0x2001, lsu_rdata=0x1234.
REQ-031 SHALL verify: load word 0x12FF -> HI address 0x1300 without macro, 0x1200 with LSU_PAGE_WRAP_EN; 0xFFFF -> 0x0000 without macro.
REQ-032 SHALL verify: store 0x5A to 0x0100 -> mem_we=1, mem_wdata=0x5A, lsu_rdata unchanged; second request during busy ignored.
REQ-033 SHALL verify: rst_n low during HI with ack pending -> mem_req low next cycle, no lsu_done, all outputs 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU memory port: scheduler op encodings and FSM states.
package lsu_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_LB   = 2'b01,
        OP_LW   = 2'b10,
        OP_SB   = 2'b11
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_port.sv
// LSU memory port: one byte/word load or byte store per request over a req/ack byte bus.
// Macro LSU_PAGE_WRAP_EN makes the high-byte address wrap within the 256-byte page.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ADR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADR_W-1:0] lsu_adr,
    input  logic             sched_valid,
    input  logic [1:0]       sched_op,
    input  logic [7:0]       sched_wdata,
    output logic             lsu_busy,
    output logic             lsu_done,
    output logic [15:0]      lsu_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [ADR_W-1:0] mem_adr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    input  logic             mem_ack
);

    lsu_state_e       r_state;
    lsu_op_e          r_op;
    logic [ADR_W-1:0] r_adr;
    logic [7:0]       r_lo_byte;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_rdata;
    logic             r_req;
    logic             r_we;
    logic [ADR_W-1:0] r_mem_adr;
    logic [7:0]       r_mem_wdata;
    logic [ADR_W-1:0] w_adr_hi;
    logic             w_accept;

`ifdef LSU_PAGE_WRAP_EN
    assign w_adr_hi = {r_adr[ADR_W-1:8], r_adr[7:0] + 8'd1};
`else
    assign w_adr_hi = r_adr + ADR_W'(1);
`endif

    assign w_accept = sched_valid && (sched_op != OP_NONE);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NONE;
            r_adr       <= '0;
            r_lo_byte   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rdata     <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_mem_adr   <= '0;
            r_mem_wdata <= '0;
        end else begin
            // NOTE: default-low each cycle turns lsu_done into a single-cycle pulse.
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_LO;
                        r_op        <= lsu_op_e'(sched_op);
                        r_adr       <= lsu_adr;
                        r_busy      <= 1'b1;
                        r_req       <= 1'b1;
                        r_we        <= (lsu_op_e'(sched_op) == OP_SB);
                        r_mem_adr   <= lsu_adr;
                        r_mem_wdata <= sched_wdata;
                    end
                end
                ST_LO: begin
                    if (mem_ack) begin
                        if (r_op == OP_LW) begin
                            r_state   <= ST_HI;
                            r_lo_byte <= mem_rdata;
                            r_mem_adr <= w_adr_hi;
                            r_we      <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_req   <= 1'b0;
                            r_we    <= 1'b0;
                            r_done  <= 1'b1;
                            if (r_op == OP_LB) begin
                                r_rdata <= {8'h00, mem_rdata};
                            end
                        end
                    end
                end
                ST_HI: begin
                    if (mem_ack) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_req   <= 1'b0;
                        r_done  <= 1'b1;
                        r_rdata <= {mem_rdata, r_lo_byte};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign lsu_busy  = r_busy;
    assign lsu_done  = r_done;
    assign lsu_rdata = r_rdata;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_adr   = r_mem_adr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: vector table plus hand sequences for busy, back-to-back and reset abort.
module tb_lsu_mem_port;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] lsu_adr = '0;
    logic        sched_valid = 1'b0;
    logic [1:0]  sched_op = 2'b00;
    logic [7:0]  sched_wdata = '0;
    logic        lsu_busy;
    logic        lsu_done;
    logic [15:0] lsu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_adr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack;

    logic        model_ack = 1'b0;
    logic        stray_ack = 1'b0;
    int          cur_wait = 0;
    int          wait_cnt = 0;
    logic [7:0]  mem [0:65535];
    logic [15:0] ph_adr[$];
    logic        ph_we[$];
    logic [7:0]  ph_wd[$];
    logic [15:0] st_adr;
    logic        st_we;
    logic [7:0]  st_wd;

    int n_checks = 0;
    int n_errors = 0;

    assign mem_ack = model_ack | stray_ack;

    lsu_mem_port #(.ADR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .lsu_adr(lsu_adr), .sched_valid(sched_valid),
        .sched_op(sched_op), .sched_wdata(sched_wdata), .lsu_busy(lsu_busy),
        .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Memory model: acks after cur_wait idle cycles of mem_req, each phase timed from its first cycle.
    always @(negedge clk) begin
        if (model_ack) begin
            model_ack = 1'b0;
            wait_cnt  = 0;
        end
        if (mem_req) begin
            if (wait_cnt == 0) begin
                st_adr = mem_adr;
                st_we  = mem_we;
                st_wd  = mem_wdata;
            end
            if (wait_cnt == cur_wait) begin
                check("bus stable", {15'd0, mem_we, mem_wdata, mem_adr}, {15'd0, st_we, st_wd, st_adr});
                model_ack = 1'b1;
                mem_rdata = mem[mem_adr];
                ph_adr.push_back(mem_adr);
                ph_we.push_back(mem_we);
                ph_wd.push_back(mem_wdata);
                if (mem_we) mem[mem_adr] = mem_wdata;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Called at a falling edge; returns just after the accepting rising edge.
    task automatic do_req(input lsu_op_e op, input logic [15:0] adr, input logic [7:0] wd);
        sched_valid = 1'b1;
        sched_op    = op;
        lsu_adr     = adr;
        sched_wdata = wd;
        @(posedge clk);
        #1;
        sched_valid = 1'b0;
        sched_op    = OP_NONE;
    endtask

    // Latency = rising edges from accept to the edge that samples lsu_done high.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (lsu_done) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) check("done timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        lsu_op_e     op;
        logic [15:0] adr;
        logic [7:0]  wd;
        int          wt;
        bit          preload;
        logic [7:0]  d_lo;
        logic [7:0]  d_hi;
        logic [15:0] exp_rd;
        int          exp_lat;
        int          exp_ph;
        logic [15:0] exp_a1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        logic [15:0] rd_before;

`ifdef LSU_PAGE_WRAP_EN
        vecs[0] = '{OP_LB, 16'h1234, 8'h00, 0, 1, 8'hA5, 8'h00, 16'h00A5, 2, 1, 16'h0000};
        vecs[1] = '{OP_LW, 16'h2000, 8'h00, 2, 1, 8'h34, 8'h12, 16'h1234, 7, 2, 16'h2001};
        vecs[2] = '{OP_LW, 16'h12FF, 8'h00, 0, 1, 8'h11, 8'h22, 16'h2211, 3, 2, 16'h1200};
        vecs[3] = '{OP_LW, 16'hFFFF, 8'h00, 0, 1, 8'h77, 8'h66, 16'h6677, 3, 2, 16'hFF00};
`else
        vecs[0] = '{OP_LB, 16'h1234, 8'h00, 0, 1, 8'hA5, 8'h00, 16'h00A5, 2, 1, 16'h0000};
        vecs[1] = '{OP_LW, 16'h2000, 8'h00, 2, 1, 8'h34, 8'h12, 16'h1234, 7, 2, 16'h2001};
        vecs[2] = '{OP_LW, 16'h12FF, 8'h00, 0, 1, 8'h11, 8'h22, 16'h2211, 3, 2, 16'h1300};
        vecs[3] = '{OP_LW, 16'hFFFF, 8'h00, 0, 1, 8'h77, 8'h66, 16'h6677, 3, 2, 16'h0000};
`endif
        vecs[4] = '{OP_SB, 16'h0100, 8'h5A, 0, 0, 8'h00, 8'h00, 16'h6677, 2, 1, 16'h0000};
        vecs[5] = '{OP_LB, 16'h0100, 8'h00, 1, 0, 8'h00, 8'h00, 16'h005A, 3, 1, 16'h0000};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, lsu_busy}, 32'd0);
        check("reset done", {31'd0, lsu_done}, 32'd0);
        check("reset req/we", {30'd0, mem_req, mem_we}, 32'd0);
        check("reset adr/wdata", {8'd0, mem_adr, mem_wdata}, 32'd0);
        check("reset rdata", {16'd0, lsu_rdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Op 00 must not start a transaction.
        sched_valid = 1'b1;
        sched_op    = OP_NONE;
        lsu_adr     = 16'h0F0F;
        @(negedge clk);
        check("op00 ignored", {30'd0, lsu_busy, mem_req}, 32'd0);
        sched_valid = 1'b0;

        // Ack while idle must have no effect.
        stray_ack = 1'b1;
        mem_rdata = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stray ack done", {31'd0, lsu_done}, 32'd0);
        end
        check("stray ack rdata", {16'd0, lsu_rdata}, 32'd0);
        stray_ack = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].preload) begin
                mem[vecs[i].adr] = vecs[i].d_lo;
                if (vecs[i].op == OP_LW) mem[vecs[i].exp_a1] = vecs[i].d_hi;
            end
            cur_wait = vecs[i].wt;
            ph_adr.delete(); ph_we.delete(); ph_wd.delete();
            do_req(vecs[i].op, vecs[i].adr, vecs[i].wd);
            wait_done(lat);
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d rdata", i), {16'd0, lsu_rdata}, {16'd0, vecs[i].exp_rd});
            check($sformatf("v%0d phases", i), ph_adr.size(), vecs[i].exp_ph);
            if (ph_adr.size() >= 1) begin
                check($sformatf("v%0d lo adr", i), {16'd0, ph_adr[0]}, {16'd0, vecs[i].adr});
                check($sformatf("v%0d lo we", i), {31'd0, ph_we[0]}, {31'd0, vecs[i].op == OP_SB});
                if (vecs[i].op == OP_SB)
                    check($sformatf("v%0d wdata", i), {24'd0, ph_wd[0]}, {24'd0, vecs[i].wd});
            end
            if (ph_adr.size() >= 2) begin
                check($sformatf("v%0d hi adr", i), {16'd0, ph_adr[1]}, {16'd0, vecs[i].exp_a1});
                check($sformatf("v%0d hi we", i), {31'd0, ph_we[1]}, 32'd0);
            end
            @(negedge clk);
            check($sformatf("v%0d done pulse", i), {30'd0, lsu_done, lsu_busy}, 32'd0);
        end

        // Request during busy is dropped, not queued.
        cur_wait = 2;
        ph_adr.delete(); ph_we.delete(); ph_wd.delete();
        rd_before = lsu_rdata;
        do_req(OP_SB, 16'h0300, 8'hC3);
        @(negedge clk);
        sched_valid = 1'b1;
        sched_op    = OP_LB;
        lsu_adr     = 16'h0400;
        @(negedge clk);
        sched_valid = 1'b0;
        sched_op    = OP_NONE;
        wait_done(lat);
        repeat (3) @(negedge clk);
        check("busy drop phases", ph_adr.size(), 1);
        check("busy drop req", {31'd0, mem_req}, 32'd0);
        check("busy drop store mem", {24'd0, mem[16'h0300]}, 32'h0000_00C3);
        check("store keeps rdata", {16'd0, lsu_rdata}, {16'd0, rd_before});

        // Back-to-back: a new request accepted in the lsu_done cycle.
        cur_wait = 0;
        mem[16'h0500] = 8'h3C;
        mem[16'h0600] = 8'hC6;
        do_req(OP_LB, 16'h0500, 8'h00);
        wait_done(lat);
        check("b2b first rdata", {16'd0, lsu_rdata}, 32'h0000_003C);
        do_req(OP_LB, 16'h0600, 8'h00);
        wait_done(lat);
        check("b2b second latency", lat, 2);
        check("b2b second rdata", {16'd0, lsu_rdata}, 32'h0000_00C6);
        @(negedge clk);

        // Reset in HI with an ack pending aborts silently.
        cur_wait = 3;
        mem[16'h4000] = 8'h01;
        mem[16'h4001] = 8'h02;
        do_req(OP_LW, 16'h4000, 8'h00);
        lat = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (mem_req && mem_adr == 16'h4001) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) check("reach HI timeout", 32'd0, 32'd1);
        #1;
        rst_n     = 1'b0;
        stray_ack = 1'b1;
        @(negedge clk);
        check("abort req", {31'd0, mem_req}, 32'd0);
        check("abort done", {31'd0, lsu_done}, 32'd0);
        check("abort busy/we", {30'd0, lsu_busy, mem_we}, 32'd0);
        check("abort adr/wdata", {8'd0, mem_adr, mem_wdata}, 32'd0);
        check("abort rdata", {16'd0, lsu_rdata}, 32'd0);
        rst_n     = 1'b1;
        stray_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post abort done", {30'd0, lsu_done, mem_req}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
